rca_seq_ctrl: RTL and testbench

Sequencer and arbiter that shares one 6-bit ripple-carry adder slice between NREQ requesters and performs NWORDS-word additions on it. The adder is carry-in-less (carry-in tied 0), so the controller does multi-word carry propagation itself. When a carry is pending, it spends a second adder pass per word to add it in. The block sits between requesting datapath units and a single external adder instance; the adder is combinational and its result is sampled in the same cycle it is driven.

---
 rtl/rca_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Multi-word add sequencer and arbiter sharing one carry-in-less ripple-carry adder slice.
// Define RCA_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed highest priority.
module rca_seq_ctrl #(
    parameter int WORD_W = 6,
    parameter int NWORDS = 4,
    parameter int NREQ   = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [NREQ-1:0]                   i_req_valid,
    output logic [NREQ-1:0]                   o_req_ready,
    input  logic [NREQ*WORD_W*NWORDS-1:0]     i_op_a,
    input  logic [NREQ*WORD_W*NWORDS-1:0]     i_op_b,
    output logic [WORD_W-1:0]                 o_add_term1,
    output logic [WORD_W-1:0]                 o_add_term2,
    input  logic [WORD_W:0]                   i_add_result,
    output logic                              o_rsp_valid,
    input  logic                              i_rsp_ready,
    output logic [$clog2(NREQ)-1:0]           o_rsp_id,
    output logic [WORD_W*NWORDS:0]            o_rsp_sum
);

    localparam int OPW = WORD_W * NWORDS;
    localparam int IDW = $clog2(NREQ);
    localparam int IXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, INC, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [OPW-1:0]     a_q;
    logic [OPW-1:0]     b_q;
    logic [OPW-1:0]     sum_q;
    logic [IDW-1:0]     id_q;
    logic [IXW-1:0]     idx_q;
    logic               carry_q;
    logic               c1_q;
    logic [WORD_W-1:0]  partial_q;
    logic               grant_any;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;
    logic               last_word;
    logic               accept;

    assign last_word = (idx_q == IXW'(NWORDS - 1));
    assign accept    = (state == IDLE) && grant_any;

`ifdef RCA_SEQ_RR_EN
    logic [IDW-1:0] rr_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`endif

    // First valid requester in priority order, starting from the pointer in round-robin mode.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef RCA_SEQ_RR_EN
            cand = IDW'((int'(rr_ptr) + i) % NREQ);
`else
            cand = IDW'(i);
`endif
            if (!grant_any && i_req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Ready is gated by reset so the grant also drops while reset is asserted.
    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && grant_any && i_rst_n) begin
            o_req_ready = NREQ'(1) << grant_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        o_add_term1 = '0;
        o_add_term2 = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                o_add_term1 = a_q[idx_q*WORD_W +: WORD_W];
                o_add_term2 = b_q[idx_q*WORD_W +: WORD_W];
                if (carry_q) begin
                    state_next = INC;
                end else if (last_word) begin
                    state_next = RESP;
                end
            end
            INC: begin
                o_add_term1 = partial_q;
                o_add_term2 = WORD_W'(1);
                state_next  = last_word ? RESP : ADD;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word datapath: an ADD pass either commits directly or, with a pending carry, defers to INC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            id_q      <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            c1_q      <= 1'b0;
            partial_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q     <= i_op_a[grant_id*OPW +: OPW];
                        b_q     <= i_op_b[grant_id*OPW +: OPW];
                        id_q    <= grant_id;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                        sum_q   <= '0;
                    end
                end
                ADD: begin
                    partial_q <= i_add_result[WORD_W-1:0];
                    c1_q      <= i_add_result[WORD_W];
                    if (!carry_q) begin
                        sum_q[idx_q*WORD_W +: WORD_W] <= i_add_result[WORD_W-1:0];
                        carry_q                       <= i_add_result[WORD_W];
                        if (!last_word) begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                INC: begin
                    sum_q[idx_q*WORD_W +: WORD_W] <= i_add_result[WORD_W-1:0];
                    carry_q                       <= c1_q | i_add_result[WORD_W];
                    if (!last_word) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rsp_valid = (state == RESP);
    assign o_rsp_id    = id_q;
    assign o_rsp_sum   = {carry_q, sum_q};

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for rca_seq_ctrl (WORD_W=6, NWORDS=4, NREQ=2) with a behavioural adder.
module tb_rca_seq_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  i_req_valid;
    logic [1:0]  o_req_ready;
    logic [47:0] i_op_a;
    logic [47:0] i_op_b;
    logic [5:0]  o_add_term1;
    logic [5:0]  o_add_term2;
    logic [6:0]  i_add_result;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [0:0]  o_rsp_id;
    logic [24:0] o_rsp_sum;

    int checks = 0;
    int errors = 0;

    rca_seq_ctrl #(.WORD_W(6), .NWORDS(4), .NREQ(2)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_op_a       (i_op_a),
        .i_op_b       (i_op_b),
        .o_add_term1  (o_add_term1),
        .o_add_term2  (o_add_term2),
        .i_add_result (i_add_result),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_sum    (o_rsp_sum)
    );

    // The external adder slice: combinational, carry-in tied to zero.
    assign i_add_result = {1'b0, o_add_term1} + {1'b0, o_add_term2};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(o_req_ready), 32'd0);
        checkOutput("rst_valid", 32'(o_rsp_valid), 32'd0);
        checkOutput("rst_sum", 32'(o_rsp_sum), 32'd0);
        checkOutput("rst_terms", {20'd0, o_add_term1, o_add_term2}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Presents a request in IDLE, checks the grant, and returns at the negedge of the first ADD pass.
    task automatic applyStimulus(input int req, input logic [23:0] a, input logic [23:0] b);
        logic [31:0] exp_ready;
        exp_ready          = 32'd1 << req;
        i_req_valid        = '0;
        i_req_valid[req]   = 1'b1;
        i_op_a[req*24 +: 24] = a;
        i_op_b[req*24 +: 24] = b;
        #1;
        checkOutput("req_ready", 32'(o_req_ready), exp_ready);
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid        = '0;
        i_op_a[req*24 +: 24] = ~a;
        i_op_b[req*24 +: 24] = ~b;
    endtask

    task automatic waitResponse(input int exp_id, input logic [24:0] exp_sum, input int exp_p, input int exp_ones);
        int count = 0;
        int ones  = 0;
        while (!o_rsp_valid && count < 20) begin
            if (o_add_term2 == 6'd1) ones++;
            @(posedge i_clk);
            count++;
            @(negedge i_clk);
        end
        checkOutput("rsp_valid", 32'(o_rsp_valid), 32'd1);
        checkOutput("pass_count", 32'(count), 32'(exp_p));
        checkOutput("rsp_sum", 32'(o_rsp_sum), 32'(exp_sum));
        checkOutput("rsp_id", 32'(o_rsp_id), 32'(exp_id));
        checkOutput("term2_ones", 32'(ones), 32'(exp_ones));
    endtask

    task automatic handshake();
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        #1;
        checkOutput("rsp_drop", 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        int grants[4];
        int n;
        logic [31:0] exp_grant;
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_op_a      = '0;
        i_op_b      = '0;
        i_rsp_ready = 1'b0;
        doReset();

        applyStimulus(0, 24'h00003F, 24'h000001);
        waitResponse(0, 25'h0000040, 5, 2);
        handshake();

        applyStimulus(1, 24'hFFFFFF, 24'h000001);
        waitResponse(1, 25'h1000000, 7, 4);
        handshake();

        applyStimulus(0, 24'hFFFFFF, 24'hFFFFFF);
        waitResponse(0, 25'h1FFFFFE, 7, 3);
        handshake();

        applyStimulus(0, 24'h123456, 24'h000000);
        waitResponse(0, 25'h0123456, 4, 0);
        handshake();

        // Stalled response with a competing request waiting.
        applyStimulus(0, 24'h000010, 24'h000020);
        waitResponse(0, 25'h0000030, 4, 0);
        i_op_a[24 +: 24] = 24'h000002;
        i_op_b[24 +: 24] = 24'h000003;
        i_req_valid[1]   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            checkOutput("stall_hold", {3'd0, o_rsp_valid, o_rsp_id, o_req_ready, o_rsp_sum},
                        {3'd0, 1'b1, 1'b0, 2'b00, 25'h0000030});
        end
        handshake();
        applyStimulus(1, 24'h000002, 24'h000003);
        waitResponse(1, 25'h0000005, 4, 0);
        handshake();

        // Reset during the INC pass of word 2.
        applyStimulus(0, 24'hFFFFFF, 24'h000001);
        repeat (4) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        checkOutput("inc2_terms", {20'd0, o_add_term1, o_add_term2}, {20'd0, 6'h3F, 6'h01});
        i_rst_n        = 1'b0;
        i_req_valid[1] = 1'b1;
        #1;
        checkOutput("midrst_ready", 32'(o_req_ready), 32'd0);
        checkOutput("midrst_valid", 32'(o_rsp_valid), 32'd0);
        checkOutput("midrst_id", 32'(o_rsp_id), 32'd0);
        checkOutput("midrst_sum", 32'(o_rsp_sum), 32'd0);
        checkOutput("midrst_terms", {20'd0, o_add_term1, o_add_term2}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(1, 24'h000005, 24'h000003);
        waitResponse(1, 25'h0000008, 4, 0);
        handshake();

        // Both requesters continuously valid.
        doReset();
        i_op_a      = {24'h000001, 24'h000001};
        i_op_b      = {24'h000002, 24'h000002};
        i_rsp_ready = 1'b1;
        i_req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            #1;
            if (o_req_ready != 2'b00) begin
                grants[n] = o_req_ready[1] ? 1 : 0;
                n++;
            end
            @(negedge i_clk);
        end
        i_req_valid = '0;
        checkOutput("grant_count", 32'(n), 32'd4);
        for (int g = 0; g < 4; g++) begin
`ifdef RCA_SEQ_RR_EN
            exp_grant = 32'(g % 2);
`else
            exp_grant = 32'd0;
`endif
            checkOutput("grant_seq", 32'(grants[g]), exp_grant);
        end
        repeat (10) @(negedge i_clk);
        i_rsp_ready = 1'b0;
        #1;
        checkOutput("drain_idle", 32'(o_rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
